nn_inference_controller: RTL and testbench

- Front-end sequencer for the full two-layer Semeion classifier datapath.
- Assembles a 256-pixel binary image from a narrow valid/ready word stream and clears the network.
- Pulses the network's load, waits for its done, and returns the 4-bit class through a valid/ready result port.
- Detects timeouts and framing errors, and keeps success/error counters.

---
 rtl/nn_inference_controller_if.sv | 24 ++
 rtl/nn_inference_controller.sv | 114 +++++++++++
 tb/tb_nn_inference_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_inference_controller_if.sv
// Pixel word stream and classification result handshakes of the inference controller.
// The controller is the slave of both: it sinks pixel words and sources results.
interface nn_inference_controller_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_last;
  logic                  pix_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [3:0]            res_class;
  logic [1:0]            res_error;

  modport master (
    output pix_data, pix_valid, pix_last, res_ready,
    input  pix_ready, res_valid, res_class, res_error
  );

  modport slave (
    input  pix_data, pix_valid, pix_last, res_ready,
    output pix_ready, res_valid, res_class, res_error
  );
endinterface

// File: rtl/nn_inference_controller.sv
// Front-end sequencer for the two-layer Semeion classifier: assembles an image from a word
// stream, clears and loads the network, waits for done and returns the class with error status.
module nn_inference_controller #(
  parameter int LAYER_1_INPUT_SIZE = 256,
  parameter int WORD_WIDTH         = 16,
  parameter int TIMEOUT_CYCLES     = 4096,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  nn_inference_controller_if.slave      bus,
  output logic [LAYER_1_INPUT_SIZE-1:0] nn_input,
  output logic                          nn_load,
  output logic                          nn_reset,
  input  logic                          nn_done,
  input  logic [3:0]                    nn_max,
  output logic [COUNT_WIDTH-1:0]        frame_count,
  output logic [COUNT_WIDTH-1:0]        error_count,
  output logic                          busy
);
  localparam int WORDS = LAYER_1_INPUT_SIZE / WORD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CLEAR, S_LOAD, S_WAIT, S_RESULT
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   wcnt;
  logic               xfer, last_word, frame_err, timeout;

  assign xfer      = bus.pix_valid & bus.pix_ready;
  assign last_word = (idx == IDX_W'(WORDS - 1));
  // pix_last must coincide exactly with the final word; in IDLE idx is 0 so any pix_last is early
  assign frame_err = xfer & (bus.pix_last != last_word);
  assign timeout   = (wcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_FILL:
        if (xfer) state_n = frame_err ? S_RESULT : (last_word ? S_CLEAR : S_FILL);
      S_CLEAR:  state_n = S_LOAD;
      S_LOAD:   state_n = S_WAIT;
      S_WAIT:   if (nn_done || timeout) state_n = S_RESULT;
      S_RESULT: if (bus.res_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready = 1'b0;
    bus.res_valid = 1'b0;
    nn_reset      = reset;
    nn_load       = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE:   begin busy = 1'b0; bus.pix_ready = ~reset; end
      S_FILL:   bus.pix_ready = ~reset;
      S_CLEAR:  nn_reset = 1'b1;
      S_LOAD:   nn_load = 1'b1;
      S_RESULT: bus.res_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      wcnt          <= '0;
      nn_input      <= '0;
      bus.res_class <= 4'h0;
      bus.res_error <= 2'b00;
      frame_count   <= '0;
      error_count   <= '0;
    end else begin
      if (xfer) begin
        nn_input[int'(idx)*WORD_WIDTH +: WORD_WIDTH] <= bus.pix_data;
        idx <= idx + 1'b1;
      end
      if (frame_err) begin
        bus.res_class <= 4'hF;
        bus.res_error <= 2'b10;
      end
      if (state == S_LOAD)      wcnt <= '0;
      else if (state == S_WAIT) wcnt <= wcnt + 1'b1;
      // done takes priority over the timeout boundary
      if (state == S_WAIT) begin
        if (nn_done) begin
          bus.res_class <= nn_max;
          bus.res_error <= 2'b00;
        end else if (timeout) begin
          bus.res_class <= 4'hF;
          bus.res_error <= 2'b01;
        end
      end
      if (state == S_RESULT && bus.res_ready) begin
        idx <= '0;
        if (bus.res_error == 2'b00) begin
          if (frame_count != '1) frame_count <= frame_count + 1'b1;
        end else begin
          if (error_count != '1) error_count <= error_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nn_inference_controller.sv
// Directed bench for nn_inference_controller: latency, pixel mapping, framing, timeout,
// result back-pressure and asynchronous reset.
module tb_nn_inference_controller;
  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] nn_input;
  logic         nn_load, nn_reset, nn_done, busy;
  logic [3:0]   nn_max;
  logic [15:0]  frame_count, error_count;

  nn_inference_controller_if #(.WORD_WIDTH(16)) bus ();

  nn_inference_controller #(
    .LAYER_1_INPUT_SIZE(256), .WORD_WIDTH(16), .TIMEOUT_CYCLES(4096), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .nn_input(nn_input), .nn_load(nn_load),
    .nn_reset(nn_reset), .nn_done(nn_done), .nn_max(nn_max),
    .frame_count(frame_count), .error_count(error_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           exp_fc = 0;
  int           exp_ec = 0;
  logic [15:0]  words [16];
  logic [255:0] exp_img;

  // Drives n words back to back starting at the next falling edge; returns on the falling
  // edge right after the last accepted word (cycle N+1).
  task automatic drive_frame(input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = words[k];
      bus.pix_last  = (k == last_at);
      checks++;
      if (bus.pix_ready !== 1'b1) begin
        errors++;
        $display("FAIL accept_word%0d: pix_ready=%b want 1", k, bus.pix_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.pix_ready !== 1'b1 ||
        frame_count !== 16'(exp_fc) || error_count !== 16'(exp_ec)) begin
      errors++;
      $display("FAIL %s: busy=%b res_valid=%b pix_ready=%b fc=%0d ec=%0d want 0 0 1 %0d %0d",
               name, busy, bus.res_valid, bus.pix_ready, frame_count, error_count, exp_fc, exp_ec);
    end
  endtask

  // Full frame, done raised 5 cycles after the load pulse; ends in RESULT at cycle N+8.
  task automatic do_classify(input logic [3:0] cls, input bit chk_img);
    drive_frame(16, 15);
    checks++;
    if (nn_reset !== 1'b1 || nn_load !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle: nn_reset=%b nn_load=%b pix_ready=%b want 1 0 0",
               nn_reset, nn_load, bus.pix_ready);
    end
    @(negedge clk);
    checks++;
    if (nn_load !== 1'b1 || nn_reset !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: nn_load=%b nn_reset=%b want 1 0", nn_load, nn_reset);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (nn_load !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b1 ||
          (chk_img && nn_input !== exp_img)) begin
        errors++;
        $display("FAIL wait_hold: nn_load=%b res_valid=%b busy=%b img=%h want img %h",
                 nn_load, bus.res_valid, busy, nn_input, exp_img);
      end
    end
    @(negedge clk);
    nn_done = 1'b1;
    nn_max  = cls;
    @(negedge clk);
    nn_done = 1'b0;
    nn_max  = 4'h0;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_class !== cls || bus.res_error !== 2'b00 ||
        (chk_img && nn_input !== exp_img)) begin
      errors++;
      $display("FAIL result: valid=%b class=%h err=%b want 1 %h 00", bus.res_valid,
               bus.res_class, bus.res_error, cls);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if (nn_reset !== 1'b1 || bus.pix_ready !== 1'b0 || busy !== 1'b0 || nn_load !== 1'b0 ||
        bus.res_valid !== 1'b0 || nn_input !== 256'd0 || bus.res_class !== 4'h0 ||
        bus.res_error !== 2'b00 || frame_count !== 16'd0 || error_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: nn_reset=%b pix_ready=%b busy=%b load=%b vld=%b fc=%0d ec=%0d",
               nn_reset, bus.pix_ready, busy, nn_load, bus.res_valid, frame_count, error_count);
    end
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_release");
  endtask

  task automatic test_pixel_map();
    exp_img = '0;
    for (int k = 0; k < 16; k++) begin
      words[k] = 16'h0001 << k;
      exp_img[17*k] = 1'b1;
    end
    do_classify(4'd7, 1'b1);
    exp_fc++;
    check_idle("nominal_done");
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < 16; k++) words[k] = 16'hFFFF;
    exp_img = {256{1'b1}};
    do_classify(4'd9, 1'b1);
    exp_fc++;
    check_idle("all_ones_done");
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    do_classify(4'd2, 1'b0);
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_class !== 4'd2 || bus.pix_ready !== 1'b0 ||
          busy !== 1'b1 || frame_count !== 16'(exp_fc)) begin
        errors++;
        $display("FAIL bp_hold: vld=%b class=%h rdy=%b busy=%b fc=%0d want 1 2 0 1 %0d",
                 bus.res_valid, bus.res_class, bus.pix_ready, busy, frame_count, exp_fc);
      end
    end
    bus.res_ready = 1'b1;
    exp_fc++;
    check_idle("bp_release");
  endtask

  task automatic test_framing();
    for (int k = 0; k < 16; k++) words[k] = 16'h1111 * 16'(k);
    drive_frame(10, 9);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_class !== 4'hF || bus.res_error !== 2'b10 ||
        nn_reset !== 1'b0 || nn_load !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL framing_early: vld=%b class=%h err=%b nn_reset=%b nn_load=%b want 1 f 10 0 0",
               bus.res_valid, bus.res_class, bus.res_error, nn_reset, nn_load);
    end
    exp_ec++;
    check_idle("framing_early_done");
    do_classify(4'd3, 1'b0);
    exp_fc++;
    check_idle("framing_followup");
    drive_frame(16, -1);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_class !== 4'hF || bus.res_error !== 2'b10 ||
        nn_reset !== 1'b0) begin
      errors++;
      $display("FAIL framing_nolast: vld=%b class=%h err=%b nn_reset=%b want 1 f 10 0",
               bus.res_valid, bus.res_class, bus.res_error, nn_reset);
    end
    exp_ec++;
    check_idle("framing_nolast_done");
  endtask

  task automatic test_timeout();
    int c;
    drive_frame(16, 15);
    @(negedge clk);
    @(negedge clk);
    c = 0;
    while (bus.res_valid !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 4096 || bus.res_class !== 4'hF || bus.res_error !== 2'b01) begin
      errors++;
      $display("FAIL timeout: cycles=%0d class=%h err=%b want 4096 f 01",
               c, bus.res_class, bus.res_error);
    end
    exp_ec++;
    check_idle("timeout_done");
  endtask

  task automatic test_reset_mid_wait();
    for (int k = 0; k < 16; k++) words[k] = 16'hBEEF;
    drive_frame(16, 15);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (nn_reset !== 1'b1 || bus.pix_ready !== 1'b0 || busy !== 1'b0 ||
        bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: nn_reset=%b pix_ready=%b busy=%b vld=%b want 1 0 0 0",
               nn_reset, bus.pix_ready, busy, bus.res_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    exp_ec = 0;
    check_idle("reset_mid_wait");
    checks++;
    if (nn_input !== 256'd0 || bus.res_class !== 4'h0 || bus.res_error !== 2'b00) begin
      errors++;
      $display("FAIL reset_regs: img=%h class=%h err=%b want 0", nn_input,
               bus.res_class, bus.res_error);
    end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    bus.pix_data  = 16'h0;
    bus.res_ready = 1'b1;
    nn_done       = 1'b0;
    nn_max        = 4'h0;
    exp_img       = '0;
    test_reset();
    test_pixel_map();
    test_all_ones();
    test_backpressure();
    test_framing();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
